// File: rtl/calc1_port_engine.sv
// -----------------------------------------------------------------------------
// calc1_port_engine
//   Two-beat command port feeding a small arithmetic engine. A nonzero cmd_in
//   carries operand 1 on data_in; the next cycle carries operand 2. The
//   registered result is presented for exactly one cycle, three cycles after
//   the command cycle. One command can be in flight at a time.
//
// Ports
//   c_clk     in   clock, all state on rising edge
//   reset_n   in   asynchronous active-low reset
//   cmd_in    in   4-bit command (1 add, 2 sub, 5 shl, 6 shr, 0 no-op)
//   data_in   in   operand 1 in command cycle, operand 2 in following cycle
//   resp_out  out  0 none, 1 success, 2 overflow/underflow/invalid
//   data_out  out  result, nonzero only while resp_out = 1
//   busy      out  high while a command occupies OP2 or EXEC
//
// State | meaning
// IDLE  | waiting for a nonzero command
// OP2   | operand 1 held, capturing operand 2 (cmd_in ignored)
// EXEC  | computing result/response into registers (cmd_in ignored)
// RESP  | response visible; a nonzero cmd_in here starts the next command
// -----------------------------------------------------------------------------
module calc1_port_engine #(
    parameter int DATA_W = 32
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic [3:0]        cmd_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [1:0]        resp_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    localparam int SHAMT_W = $clog2(DATA_W);

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP2  = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [1:0]        resp_q, resp_d;
    logic [DATA_W-1:0] res_q, res_d;

    logic [DATA_W:0]   sum;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]        exec_resp;
    logic [DATA_W-1:0] exec_res;

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            resp_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            resp_q  <= resp_d;
            res_q   <= res_d;
        end
    end

    // Datapath: error responses always carry a zero result.
    always_comb begin
        sum       = {1'b0, op1_q} + {1'b0, op2_q};
        shamt     = op2_q[SHAMT_W-1:0];
        exec_resp = RESP_ERR;
        exec_res  = '0;
        case (cmd_q)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    exec_resp = RESP_OK;
                    exec_res  = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2_q <= op1_q) begin
                    exec_resp = RESP_OK;
                    exec_res  = op1_q - op2_q;
                end
            end
            CMD_SHL: begin
                exec_resp = RESP_OK;
                exec_res  = op1_q << shamt;
            end
            CMD_SHR: begin
                exec_resp = RESP_OK;
                exec_res  = op1_q >> shamt;
            end
            default: begin
                exec_resp = RESP_ERR;
                exec_res  = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        resp_d  = resp_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (cmd_in != 4'd0) begin
                    cmd_d   = cmd_in;
                    op1_d   = data_in;
                    state_d = OP2;
                end
            end
            OP2: begin
                op2_d   = data_in;
                state_d = EXEC;
            end
            EXEC: begin
                resp_d  = exec_resp;
                res_d   = exec_res;
                state_d = RESP;
            end
            RESP: begin
                if (cmd_in != 4'd0) begin
                    cmd_d   = cmd_in;
                    op1_d   = data_in;
                    state_d = OP2;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from the state register so reset clears them at once.
    assign resp_out = (state_q == RESP) ? resp_q : 2'd0;
    assign data_out = (state_q == RESP) ? res_q : '0;
    assign busy     = (state_q == OP2) || (state_q == EXEC);

endmodule

// File: tb/tb_calc1_port_engine.sv
module tb_calc1_port_engine;

    logic        c_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  cmd_in;
    logic [31:0] data_in;
    logic [1:0]  resp_out;
    logic [31:0] data_out;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    calc1_port_engine #(.DATA_W(32)) dut (
        .c_clk    (c_clk),
        .reset_n  (reset_n),
        .cmd_in   (cmd_in),
        .data_in  (data_in),
        .resp_out (resp_out),
        .data_out (data_out),
        .busy     (busy)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // Reference: what the specification says each command returns.
    function automatic void model(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [1:0] r, output logic [31:0] d);
        longint unsigned s;
        int unsigned     amt;
        amt = b % 32;
        r = 2'd2;
        d = 32'd0;
        case (c)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s <= 64'hFFFF_FFFF) begin
                    r = 2'd1;
                    d = a + b;
                end
            end
            4'd2: begin
                if (a >= b) begin
                    r = 2'd1;
                    d = a - b;
                end
            end
            4'd5: begin
                r = 2'd1;
                d = a << amt;
            end
            4'd6: begin
                r = 2'd1;
                d = a >> amt;
            end
            default: begin
                r = 2'd2;
                d = 32'd0;
            end
        endcase
    endfunction

    // Drives one command starting at a falling edge; returns what the DUT
    // shows in the RESP cycle plus whether OP2/EXEC/RESP looked as required.
    task automatic do_cmd(input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b,
                          output logic [1:0] r, output logic [31:0] d,
                          output logic quiet);
        quiet   = 1'b1;
        cmd_in  = c;
        data_in = a;
        @(negedge c_clk);
        if (resp_out !== 2'd0 || data_out !== 32'd0 || busy !== 1'b1) quiet = 1'b0;
        cmd_in  = 4'd0;
        data_in = b;
        @(negedge c_clk);
        if (resp_out !== 2'd0 || data_out !== 32'd0 || busy !== 1'b1) quiet = 1'b0;
        data_in = $urandom;
        @(negedge c_clk);
        r = resp_out;
        d = data_out;
        if (busy !== 1'b0) quiet = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_in  = 4'd0;
        data_in = 32'd0;
        #1;
        vectors++;
        if (resp_out !== 2'd0 || data_out !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got resp=%0d data=%h busy=%b, want 0 0 0",
                     resp_out, data_out, busy);
        end
        repeat (2) @(negedge c_clk);
        vectors++;
        if (resp_out !== 2'd0 || data_out !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held: got resp=%0d data=%h busy=%b, want 0 0 0",
                     resp_out, data_out, busy);
        end
        reset_n = 1'b1;
        @(negedge c_clk);
    endtask

    task automatic check_one(input string name, input logic [3:0] c,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] er, input logic [31:0] ed);
        logic [1:0]  r;
        logic [31:0] d;
        logic        q;
        do_cmd(c, a, b, r, d, q);
        vectors++;
        if (r !== er || d !== ed || q !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got resp=%0d data=%h quiet=%b, want resp=%0d data=%h quiet=1",
                     name, r, d, q, er, ed);
        end
    endtask

    task automatic test_add_walk();
        for (int k = 0; k < 32; k++)
            check_one($sformatf("add_walk_%0d", k), 4'd1, 32'd1 << k, 32'd0,
                      2'd1, 32'd1 << k);
        @(negedge c_clk);
    endtask

    task automatic test_add_overflow();
        check_one("add_carry", 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0);
        check_one("add_7fff", 4'd1, 32'h7FFF_FFFF, 32'd1, 2'd1, 32'h8000_0000);
        @(negedge c_clk);
    endtask

    task automatic test_sub();
        check_one("sub_7_5", 4'd2, 32'd7, 32'd5, 2'd1, 32'd2);
        check_one("sub_5_7", 4'd2, 32'd5, 32'd7, 2'd2, 32'd0);
        check_one("sub_9_9", 4'd2, 32'd9, 32'd9, 2'd1, 32'd0);
        @(negedge c_clk);
    endtask

    task automatic test_shift();
        check_one("shl_31", 4'd5, 32'd1, 32'd31, 2'd1, 32'h8000_0000);
        check_one("shr_21", 4'd6, 32'h8000_0000, 32'h21, 2'd1, 32'h4000_0000);
        check_one("shl_big", 4'd5, 32'h0000_00F0, 32'hFFFF_FFE4, 2'd1, 32'h0000_0F00);
        @(negedge c_clk);
    endtask

    task automatic test_invalid();
        logic [3:0] codes [6] = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd12, 4'd15};
        foreach (codes[i])
            check_one($sformatf("invalid_%0d", codes[i]), codes[i], $urandom,
                      $urandom, 2'd2, 32'd0);
        @(negedge c_clk);
    endtask

    task automatic test_drop();
        int          nresp;
        logic [1:0]  r1;
        logic [31:0] d1;
        cmd_in  = 4'd1;
        data_in = 32'd10;
        @(negedge c_clk);            // OP2: cmd ignored, data is op2
        cmd_in  = 4'd2;
        data_in = 32'd20;
        @(negedge c_clk);            // EXEC: this command is dropped
        cmd_in  = 4'd2;
        data_in = 32'd99;
        @(negedge c_clk);            // RESP
        r1 = resp_out;
        d1 = data_out;
        nresp = (resp_out != 2'd0) ? 1 : 0;
        cmd_in  = 4'd0;
        data_in = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge c_clk);
            if (resp_out != 2'd0) nresp++;
        end
        vectors++;
        if (r1 !== 2'd1 || d1 !== 32'd30) begin
            miscompares++;
            $display("FAIL drop_first: got resp=%0d data=%h, want resp=1 data=%h",
                     r1, d1, 32'd30);
        end
        vectors++;
        if (nresp != 1) begin
            miscompares++;
            $display("FAIL drop_count: got %0d responses, want 1", nresp);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4] = '{4'd1, 4'd2, 4'd5, 4'd6};
        logic [3:0]  c;
        logic [31:0] a, b, ed;
        logic [1:0]  er;
        for (int i = 0; i < 8; i++) begin
            c = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = (c == 4'd2) ? $urandom_range(0, 1000) : $urandom;
            model(c, a, b, er, ed);
            check_one($sformatf("b2b_%0d", i), c, a, b, er, ed);
        end
        @(negedge c_clk);
        vectors++;
        if (resp_out !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got resp=%0d busy=%b, want 0 0", resp_out, busy);
        end
    endtask

    task automatic test_random();
        logic [3:0]  c;
        logic [31:0] a, b, ed;
        logic [1:0]  er;
        int          gap;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 6))
                0: c = 4'd1;
                1: c = 4'd2;
                2: c = 4'd5;
                3: c = 4'd6;
                4: c = 4'($urandom_range(1, 15));
                default: c = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2;
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFFF - a + 32'($urandom_range(0, 2)) - 32'd1;
            if ($urandom_range(0, 3) == 0) b = a - 32'($urandom_range(0, 2)) + 32'd1;
            model(c, a, b, er, ed);
            check_one($sformatf("rand_%0d", i), c, a, b, er, ed);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge c_clk);
                vectors++;
                if (resp_out !== 2'd0 || data_out !== 32'd0 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_idle_%0d: got resp=%0d data=%h busy=%b, want 0 0 0",
                             i, resp_out, data_out, busy);
                end
            end
        end
        @(negedge c_clk);
    endtask

    task automatic test_reset_mid();
        int          nresp;
        logic [1:0]  r;
        logic [31:0] d;
        logic        q;
        // Abort 2+2 while it sits in EXEC.
        cmd_in  = 4'd1;
        data_in = 32'd2;
        @(negedge c_clk);
        cmd_in  = 4'd0;
        data_in = 32'd2;
        @(negedge c_clk);
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (resp_out !== 2'd0 || data_out !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_exec_now: got resp=%0d data=%h busy=%b, want 0 0 0",
                     resp_out, data_out, busy);
        end
        @(negedge c_clk);
        reset_n = 1'b1;
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge c_clk);
            if (resp_out != 2'd0 || busy != 1'b0) nresp++;
        end
        vectors++;
        if (nresp != 0) begin
            miscompares++;
            $display("FAIL rst_no_resp: got %0d active cycles, want 0", nresp);
        end
        check_one("rst_then_1p1", 4'd1, 32'd1, 32'd1, 2'd1, 32'd2);

        // Abort while the response itself is on the outputs.
        do_cmd(4'd1, 32'd5, 32'd6, r, d, q);
        vectors++;
        if (r !== 2'd1 || d !== 32'd11) begin
            miscompares++;
            $display("FAIL rst_resp_pre: got resp=%0d data=%h, want resp=1 data=%h",
                     r, d, 32'd11);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (resp_out !== 2'd0 || data_out !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_resp_now: got resp=%0d data=%h, want 0 0", resp_out, data_out);
        end
        @(negedge c_clk);
        // Command presented together with release: first edge must take it.
        reset_n = 1'b1;
        check_one("rst_first_edge", 4'd2, 32'd100, 32'd1, 2'd1, 32'd99);
        @(negedge c_clk);
    endtask

    initial begin
        test_reset();
        test_add_walk();
        test_add_overflow();
        test_sub();
        test_shift();
        test_invalid();
        test_drop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc1_port_engine.md
CALC1_PORT_ENGINE -- requirements
Module: calc1_port_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; SHAMT_W = $clog2(DATA_W).
REQ-002 SHALL have port c_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_in  input  4  command code; nonzero marks operand-1 cycle.
REQ-005 SHALL have port data_in  input  DATA_W  operand 1 in command cycle, operand 2 in following cycle.
REQ-006 SHALL have port resp_out  output  2  response: 0 none, 1 success, 2 overflow/underflow/invalid, 3 unused.
REQ-007 SHALL have port data_out  output  DATA_W  result; valid only while resp_out = 1.
REQ-008 SHALL have port busy  output  1  high while a command is in flight (OP2 or EXEC state).

Function
REQ-009 SHALL decode cmd: 1 add, 2 subtract, 5 shift left, 6 shift right (logical); 0 no-op; all others invalid.
REQ-010 SHALL implement FSM states IDLE, OP2, EXEC, RESP.
REQ-011 IDLE: cmd_in != 0 -> latch cmd_in and data_in as op1, go OP2; cmd_in = 0 -> stay IDLE.
REQ-012 OP2: latch data_in as op2 regardless of cmd_in (cmd_in ignored), go EXEC.
REQ-013 EXEC: compute result and response into registers, go RESP.
REQ-014 RESP: drive resp_out/data_out for exactly one cycle. If cmd_in != 0 that cycle, capture new command (op1) and go OP2; else go IDLE.
REQ-015 Latency: response SHALL appear exactly 3 cycles after the command cycle (command at edge N -> resp_out valid in cycle after edge N+3).
REQ-016 Add: result = op1 + op2 computed DATA_W+1 wide; carry out -> resp 2, data_out 0; else resp 1.
REQ-017 Subtract: op2 > op1 -> resp 2, data_out 0; else resp 1, data_out = op1 - op2 (op1 == op2 gives resp 1, data 0).
REQ-018 Shifts: amount = op2[SHAMT_W-1:0]; upper bits of op2 ignored; bits shifted out discarded; always resp 1.
REQ-019 Invalid code: resp 2, data_out 0, still 3-cycle latency.
REQ-020 Outside RESP, resp_out SHALL be 0 and data_out SHALL be 0.
REQ-021 busy SHALL be 1 in OP2 and EXEC, 0 in IDLE and RESP.
REQ-022 Maximum throughput: one command per 3 cycles (back-to-back via REQ-014); commands presented in OP2 or EXEC SHALL be dropped silently.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, resp_out 0, data_out 0, busy 0, cmd/op1/op2 registers 0, without waiting for c_clk.
REQ-024 Reset asserted mid-command (OP2, EXEC or RESP) SHALL abort it; no response for that command after release.
REQ-025 First edge after reset_n deassertion SHALL be able to accept a command.

Verification
REQ-026 Add walking one: for k = 0..31, cmd 1, op1 = 1<<k, op2 = 0 -> resp 1, data_out = 1<<k, 3 cycles after command.
REQ-027 Add overflow: cmd 1, 0xFFFFFFFF + 0x00000001 -> resp 2, data_out 0; 0x7FFFFFFF + 1 -> resp 1, 0x80000000.
REQ-028 Subtract: 7 - 5 -> resp 1, data 2; 5 - 7 -> resp 2, data 0; 9 - 9 -> resp 1, data 0.
REQ-029 Shift: cmd 5, 1 by 31 -> 0x80000000; cmd 6, 0x80000000 by 0x21 (amount 1) -> 0x40000000; both resp 1.
REQ-030 Invalid/drop: cmd 3 -> resp 2, data 0; second command issued during EXEC -> exactly one response; command issued in RESP cycle -> its response 3 cycles later.
REQ-031 Reset: reset_n pulsed low during EXEC of 2+2 -> outputs 0 immediately, no response, next 1+1 -> resp 1, data 2.
